wb_config_loader: RTL and testbench
===================================

// Module: wb_config_loader
// PURPOSE
//  Wishbone initiator that streams an FPGA bitstream into one config region of the fabric.
//  Accepts 32-bit words on a valid/ready stream and writes each to the region's data register.
//  Then issues one commit write to the region's control register, and reports done or error.
//  Sits in front of the wishbone_configuratorinator responders; one loader serves all regions.
// PARAMETERS
//  BASE_ADDR      32'h3000_0000  address of region 0; region r is at BASE_ADDR + (r << 24)
//  NUM_REGIONS    2              number of config regions; region_i >= NUM_REGIONS is an error
//  DATA_OFFSET    32'h0          byte offset of the per-region data (shift) register
//  CTRL_OFFSET    32'h4          byte offset of the per-region control (commit) register
//  CNT_W          16             width of word count
//  TIMEOUT        255            max cycles a bus cycle waits for ack (>=1)
// PORTS
//  wb_clk_i      in   1      fabric/wishbone clock
//  wb_rst_ni     in   1      async active-low reset
//  start_i       in   1      one-cycle pulse; latches region_i and count_i
//  region_i      in   8      target config region
//  count_i       in   CNT_W  number of bitstream words to write (0 allowed)
//  s_data_i      in   32     bitstream word
//  s_valid_i     in   1      s_data_i valid
//  s_ready_o     out  1      word accepted when s_valid_i & s_ready_o
//  wbm_cyc_o     out  1      wishbone cycle
//  wbm_stb_o     out  1      wishbone strobe
//  wbm_we_o      out  1      always 1 during a cycle (write-only master)
//  wbm_sel_o     out  4      4'hF during a cycle, else 4'h0
//  wbm_adr_o     out  32     write address
//  wbm_dat_o     out  32     write data
//  wbm_ack_i     in   1      responder acknowledge
//  busy_o        out  1      high from accepted start until DONE/ERR exit
//  done_o        out  1      one-cycle pulse on successful completion
//  err_o         out  1      sticky; set on timeout or bad region, cleared by next accepted start
//  words_o       out  CNT_W  words acknowledged in current/last load
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-cycle drops cyc/stb at once (async).
//  States: IDLE, FETCH, WRITE, COMMIT, DONE, ERR.
//  IDLE: start_i -> latch region/count, clear err_o and words_o, busy_o=1.
//    region_i >= NUM_REGIONS -> ERR; count_i==0 -> COMMIT; else FETCH.
//  FETCH: s_ready_o=1; on handshake register word -> WRITE next cycle.
//    s_ready_o is 0 in every other state.
//  WRITE: cyc=stb=1, adr=BASE_ADDR+(region<<24)+DATA_OFFSET, dat=word; held stable until ack.
//    ack -> words_o+1; cyc/stb deassert next cycle (no back-to-back: >=1 idle cycle between).
//    Then remaining>0 -> FETCH, else COMMIT.
//  COMMIT: cyc=stb=1, adr=...+CTRL_OFFSET, dat=32'h1; ack -> DONE.
//  DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
//  ERR: err_o=1, busy_o=0 -> IDLE (one cycle).
//  Timeout: cycle counter reset on entering WRITE/COMMIT.
//    TIMEOUT cycles without ack -> drop cyc/stb, go to ERR.
//    Remaining stream words are not consumed.
//  Latency: stream handshake to stb = 1 cycle; ack to next s_ready = 1 cycle.
//  start_i while busy_o=1 is ignored.
//  wbm_ack_i outside WRITE/COMMIT is ignored.
//  Ack on the same cycle the timeout expires counts as ack (ack has priority).
//  Address arithmetic is 32-bit modulo.
// STRUCTURE
//  Shared package fabric_cfg_pkg: region stride (24) and the DATA_OFFSET/CTRL_OFFSET constants,
//    also used by wishbone_configuratorinator, plus the loader state enum.
//  One sub-module: wb_timeout_ctr (load, tick, expire flag), reusable by other masters.
// TESTING
//  1. start region=1, count=3, words A,B,C, ack after 1 cycle
//     -> writes 0x3100_0000 = A,B,C; 0x3100_0004 = 1; done_o pulse; words_o=3.
//  2. count=0 -> single commit write to 0x3000_0004; done_o; no s_ready_o.
//  3. ack delayed 5 cycles on word 2 -> adr/dat/stb stable all 5 cycles; result as case 1.
//  4. TIMEOUT=8, ack never -> stb low after 8 cycles; err_o=1; busy_o=0; done_o never.
//  5. region=2 with NUM_REGIONS=2 -> ERR, no bus cycle.
//     Next start with valid region clears err_o.
//  6. Assert wb_rst_ni low during WRITE -> cyc/stb 0 immediately.
//     After release, IDLE; start_i pulsed while busy_o=1 has no effect.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared fabric configuration constants and the bitstream loader state encoding.
// Also used by the configuration responders so the address map stays in one place.
package fabric_cfg_pkg;

    localparam int unsigned REGION_SHIFT    = 24;
    localparam logic [31:0] CFG_DATA_OFFSET = 32'h0000_0000;
    localparam logic [31:0] CFG_CTRL_OFFSET = 32'h0000_0004;
    localparam logic [31:0] CFG_COMMIT_WORD = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_e;

    // Address of a register inside a region; wraps modulo 2^32.
    function automatic logic [31:0] region_addr(input logic [31:0] base,
                                                input logic [7:0]  region,
                                                input logic [31:0] offset);
        return base + ({24'h00_0000, region} << REGION_SHIFT) + offset;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles while tick is high, cleared by load.
// expired flags the TIMEOUT-th consecutive ticking cycle.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter, saturating at the last counted cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= '0;
        end else if (tick && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = tick && (cnt_r == LAST);

endmodule

// File: rtl/wb_config_loader.sv
// Wishbone write-only initiator streaming bitstream words into one config region,
// followed by a commit write to the region control register.
module wb_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned NUM_REGIONS = 2,
    parameter logic [31:0] DATA_OFFSET = CFG_DATA_OFFSET,
    parameter logic [31:0] CTRL_OFFSET = CFG_CTRL_OFFSET,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic [7:0]       region_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [31:0]      s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_o
);

    loader_state_e    state_r, next_state_s;
    logic [7:0]       region_r;
    logic [CNT_W-1:0] remaining_r, words_r;
    logic [31:0]      adr_r, dat_r;
    logic             cyc_r, ready_r, busy_r, done_r, err_r;
    logic             start_ok_s, bad_region_s, hs_s, ack_s, expired_s;

    assign start_ok_s   = (state_r == ST_IDLE) && start_i;
    assign bad_region_s = ({24'h00_0000, region_i} >= NUM_REGIONS);
    assign hs_s         = ready_r && s_valid_i;
    assign ack_s        = cyc_r && wbm_ack_i &&
                          ((state_r == ST_WRITE) || (state_r == ST_COMMIT));

    // The watchdog only runs while a bus cycle is actually on the wire.
    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .load    (!cyc_r),
        .tick    (cyc_r),
        .expired (expired_s)
    );

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; ack wins over a same-cycle timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start_i) begin
                    next_state_s = ST_IDLE;
                end else if (bad_region_s) begin
                    next_state_s = ST_ERR;
                end else if (count_i == '0) begin
                    next_state_s = ST_COMMIT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (hs_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WRITE: begin
                if (ack_s) begin
                    if (remaining_r == CNT_W'(1)) begin
                        next_state_s = ST_COMMIT;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end else if (expired_s) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_COMMIT: begin
                if (ack_s) begin
                    next_state_s = ST_DONE;
                end else if (expired_s) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_COMMIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath, all derived from the upcoming state.
    // The commit cycle starts one cycle after entering COMMIT, leaving an idle bus cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            region_r    <= 8'h00;
            remaining_r <= '0;
            words_r     <= '0;
            adr_r       <= 32'h0000_0000;
            dat_r       <= 32'h0000_0000;
            cyc_r       <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_FETCH);
            busy_r  <= (next_state_s == ST_FETCH) || (next_state_s == ST_WRITE) ||
                       (next_state_s == ST_COMMIT);
            done_r  <= (next_state_s == ST_DONE);
            cyc_r   <= (next_state_s == ST_WRITE) ||
                       ((next_state_s == ST_COMMIT) && (state_r == ST_COMMIT));

            if (next_state_s == ST_ERR) begin
                err_r <= 1'b1;
            end else if (start_ok_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end

            if (start_ok_s) begin
                region_r    <= region_i;
                remaining_r <= count_i;
                words_r     <= '0;
            end else if (ack_s && (state_r == ST_WRITE)) begin
                remaining_r <= remaining_r - CNT_W'(1);
                words_r     <= words_r + CNT_W'(1);
            end else begin
                remaining_r <= remaining_r;
                words_r     <= words_r;
            end

            if (next_state_s == ST_WRITE) begin
                adr_r <= region_addr(BASE_ADDR, region_r, DATA_OFFSET);
                dat_r <= hs_s ? s_data_i : dat_r;
            end else if (next_state_s == ST_COMMIT) begin
                adr_r <= region_addr(BASE_ADDR, region_r, CTRL_OFFSET);
                dat_r <= CFG_COMMIT_WORD;
            end else begin
                adr_r <= 32'h0000_0000;
                dat_r <= 32'h0000_0000;
            end
        end
    end

    assign s_ready_o = ready_r;
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = cyc_r;
    assign wbm_sel_o = {4{cyc_r}};
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign err_o     = err_r;
    assign words_o   = words_r;

endmodule

// File: tb/tb_wb_config_loader.sv
// Directed bench for wb_config_loader: a cycle-driven stream source and Wishbone
// responder with per-transfer ack delays, checked against hand-computed results.
module tb_wb_config_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  region = 8'h00;
    logic [15:0] count = 16'h0000;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack = 1'b0;
    logic        busy, done, err;
    logic [15:0] words_cnt;

    always #5 clk = ~clk;

    wb_config_loader #(
        .BASE_ADDR(32'h3000_0000), .NUM_REGIONS(2), .DATA_OFFSET(32'h0),
        .CTRL_OFFSET(32'h4), .CNT_W(16), .TIMEOUT(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .region_i(region),
        .count_i(count), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack), .busy_o(busy),
        .done_o(done), .err_o(err), .words_o(words_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] stim[8];
    int          dly[8];
    logic [31:0] log_adr[8], log_dat[8];
    int nlog, n_ready, n_done, n_consumed, max_run, stable_bad, gap_bad, lat_bad, timed_out;
    int mid_start;
    logic err_after_start;

    // Pulse start, then serve stream and bus cycle by cycle until done/err (plus a short tail).
    task automatic run_load(input logic [7:0] rg, input logic [15:0] cnt, input int nw);
        int sidx, txn, run, tail;
        logic hs_prev, ack_prev;
        logic [31:0] ref_adr, ref_dat;
        sidx = 0; txn = 0; run = 0; tail = -1; hs_prev = 1'b0; ack_prev = 1'b0;
        ref_adr = 32'h0; ref_dat = 32'h0;
        nlog = 0; n_ready = 0; n_done = 0; max_run = 0; stable_bad = 0; gap_bad = 0;
        lat_bad = 0; timed_out = 1;
        @(negedge clk); start = 1'b1; region = rg; count = cnt;
        @(negedge clk); start = 1'b0;
        err_after_start = err;
        for (int c = 0; c < 200; c++) begin
            if (hs_prev) begin
                sidx++;
                if (stb !== 1'b1) lat_bad++;
            end
            if (ack_prev && (cyc !== 1'b0)) gap_bad++;
            hs_prev = 1'b0; ack_prev = 1'b0; ack = 1'b0;
            if (s_ready) n_ready++;
            if (done) n_done++;
            if (stb) begin
                run++;
                if (run > max_run) max_run = run;
                if (run == 1) begin
                    ref_adr = adr; ref_dat = dat;
                end else if ((adr !== ref_adr) || (dat !== ref_dat)) begin
                    stable_bad++;
                end
                if ((txn < 8) && (dly[txn] != 0) && (run == dly[txn])) begin
                    ack = 1'b1; ack_prev = 1'b1;
                    if (nlog < 8) begin log_adr[nlog] = adr; log_dat[nlog] = dat; end
                    nlog++; txn++;
                end
            end else begin
                run = 0;
            end
            s_valid = (sidx < nw);
            s_data  = ((sidx < nw) && (sidx < 8)) ? stim[sidx] : 32'h0;
            hs_prev = s_valid && s_ready;
            if ((c == 2) && (mid_start != 0)) begin
                start = 1'b1; region = 8'd5; count = 16'd0;
            end else begin
                start = 1'b0;
            end
            if ((tail < 0) && (done || err)) tail = 3;
            if (tail == 0) begin
                timed_out = 0;
                break;
            end
            if (tail > 0) tail--;
            @(negedge clk);
        end
        n_consumed = sidx;
        s_valid = 1'b0; ack = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({cyc, stb, we, sel, s_ready, busy, done, err} !== 11'h000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0", {cyc, stb, we, sel, s_ready, busy, done, err});
        end
        n_checks++;
        if ({adr, dat, words_cnt} !== 80'h0) begin
            n_fail++; $display("FAIL reset_data: adr %h dat %h words %0d required 0", adr, dat, words_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Checks common to the three-word loads into region 1.
    task automatic check_three_words(input string tag);
        n_checks++;
        if ((timed_out != 0) || (nlog != 4)) begin
            n_fail++; $display("FAIL %s_nlog: got %0d writes (timeout %0d) required 4", tag, nlog, timed_out);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ((log_adr[i] !== 32'h3100_0000) || (log_dat[i] !== stim[i])) begin
                n_fail++; $display("FAIL %s_data%0d: got %h=%h required 31000000=%h", tag, i, log_adr[i], log_dat[i], stim[i]);
            end
        end
        n_checks++;
        if ((log_adr[3] !== 32'h3100_0004) || (log_dat[3] !== 32'h1)) begin
            n_fail++; $display("FAIL %s_commit: got %h=%h required 31000004=1", tag, log_adr[3], log_dat[3]);
        end
        n_checks++;
        if ((n_done != 1) || (words_cnt !== 16'd3) || (err !== 1'b0) || (busy !== 1'b0)) begin
            n_fail++; $display("FAIL %s_status: done %0d words %0d err %b busy %b required 1 3 0 0", tag, n_done, words_cnt, err, busy);
        end
        n_checks++;
        if ((gap_bad != 0) || (lat_bad != 0) || (stable_bad != 0)) begin
            n_fail++; $display("FAIL %s_timing: gap %0d lat %0d stable %0d required 0", tag, gap_bad, lat_bad, stable_bad);
        end
    endtask

    task automatic test_stream_load();
        stim[0] = 32'hA5A5_0001; stim[1] = 32'h1234_5678; stim[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) dly[i] = 1;
        run_load(8'd1, 16'd3, 3);
        check_three_words("load");
    endtask

    task automatic test_zero_count();
        for (int i = 0; i < 8; i++) dly[i] = 1;
        run_load(8'd0, 16'd0, 0);
        n_checks++;
        if ((nlog != 1) || (log_adr[0] !== 32'h3000_0004) || (log_dat[0] !== 32'h1)) begin
            n_fail++; $display("FAIL zero_commit: got %0d writes %h=%h required 1 write 30000004=1", nlog, log_adr[0], log_dat[0]);
        end
        n_checks++;
        if ((n_ready != 0) || (n_done != 1) || (words_cnt !== 16'd0)) begin
            n_fail++; $display("FAIL zero_status: ready %0d done %0d words %0d required 0 1 0", n_ready, n_done, words_cnt);
        end
    endtask

    task automatic test_ack_delay();
        for (int i = 0; i < 8; i++) dly[i] = 1;
        dly[1] = 6;
        run_load(8'd1, 16'd3, 3);
        check_three_words("delay");
        n_checks++;
        if (max_run != 6) begin
            n_fail++; $display("FAIL delay_stb_len: got %0d cycles required 6", max_run);
        end
    endtask

    task automatic test_timeout();
        stim[0] = 32'h0BAD_0001; stim[1] = 32'h0BAD_0002;
        for (int i = 0; i < 8; i++) dly[i] = 0;
        run_load(8'd0, 16'd2, 2);
        n_checks++;
        if (max_run != 8) begin
            n_fail++; $display("FAIL timeout_len: got %0d stb cycles required 8", max_run);
        end
        n_checks++;
        if ((err !== 1'b1) || (busy !== 1'b0) || (n_done != 0) || (stb !== 1'b0)) begin
            n_fail++; $display("FAIL timeout_status: err %b busy %b done %0d stb %b required 1 0 0 0", err, busy, n_done, stb);
        end
        n_checks++;
        if ((n_consumed != 1) || (words_cnt !== 16'd0) || (nlog != 0)) begin
            n_fail++; $display("FAIL timeout_stream: consumed %0d words %0d acks %0d required 1 0 0", n_consumed, words_cnt, nlog);
        end
    endtask

    task automatic test_bad_region();
        for (int i = 0; i < 8; i++) dly[i] = 1;
        run_load(8'd2, 16'd1, 1);
        n_checks++;
        if ((err !== 1'b1) || (busy !== 1'b0) || (max_run != 0) || (n_ready != 0)) begin
            n_fail++; $display("FAIL badreg: err %b busy %b stb %0d ready %0d required 1 0 0 0", err, busy, max_run, n_ready);
        end
        run_load(8'd0, 16'd0, 0);
        n_checks++;
        if ((err_after_start !== 1'b0) || (err !== 1'b0) || (n_done != 1)) begin
            n_fail++; $display("FAIL badreg_clear: err %b/%b done %0d required 0/0 1", err_after_start, err, n_done);
        end
    endtask

    task automatic test_reset_midcycle();
        int waited;
        waited = 0;
        @(negedge clk); start = 1'b1; region = 8'd1; count = 16'd2;
        @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 32'hCAFE_0001;
        while ((stb !== 1'b1) && (waited < 10)) begin
            @(negedge clk); waited++;
        end
        s_valid = 1'b0;
        n_checks++;
        if (stb !== 1'b1) begin
            n_fail++; $display("FAIL midrst_stb: got %b required 1", stb);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ((cyc !== 1'b0) || (stb !== 1'b0) || (busy !== 1'b0)) begin
            n_fail++; $display("FAIL midrst_drop: cyc %b stb %b busy %b required 0", cyc, stb, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ((busy !== 1'b0) || (s_ready !== 1'b0) || (cyc !== 1'b0)) begin
            n_fail++; $display("FAIL midrst_idle: busy %b ready %b cyc %b required 0", busy, s_ready, cyc);
        end
        stim[0] = 32'h5EED_0042;
        for (int i = 0; i < 8; i++) dly[i] = 1;
        mid_start = 1;
        run_load(8'd1, 16'd1, 1);
        mid_start = 0;
        n_checks++;
        if ((nlog != 2) || (log_adr[0] !== 32'h3100_0000) || (log_dat[0] !== 32'h5EED_0042) ||
            (log_adr[1] !== 32'h3100_0004)) begin
            n_fail++; $display("FAIL busy_start: %0d writes %h=%h %h required 2 31000000=5eed0042 31000004", nlog, log_adr[0], log_dat[0], log_adr[1]);
        end
        n_checks++;
        if ((err !== 1'b0) || (n_done != 1) || (words_cnt !== 16'd1)) begin
            n_fail++; $display("FAIL busy_status: err %b done %0d words %0d required 0 1 1", err, n_done, words_cnt);
        end
    endtask

    initial begin
        mid_start = 0;
        test_reset();
        test_stream_load();
        test_zero_count();
        test_ack_delay();
        test_timeout();
        test_bad_region();
        test_reset_midcycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
